// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings, the reset PC,
// the instruction field positions and the fetch queue entry layout.
package mips_pkg;

    // Fetch PC after reset
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Instruction field slice positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Primary opcodes recognised by decode
    typedef enum logic [5:0] {
        OP_R     = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0a,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    // R-type function codes recognised by decode
    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2a
    } funct_e;

    // One fetch queue slot: the word and the PC it was read from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [5:0] instr_op(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] instr_funct(input logic [31:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry synchronous FIFO with flush.
// Organised as a head register (always the visible output) plus one tail
// slot, so the output only moves on a pop or on a push into an empty queue;
// an empty queue keeps showing the last word it held.
module fetch_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         pop_ok;
    logic         push_ok;

    // Guard against pop-when-empty and push-when-full without a pop
    assign pop_ok  = pop & (cnt != 2'd0);
    assign push_ok = push & ((cnt != 2'd2) | pop_ok);
    assign dout    = head;

    // Queue storage and occupancy; flush empties but leaves head untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) head <= din;
                    else             tail <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) head <= tail;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end for the single-issue MIPS core.
// Keeps the fetch PC, issues one word read per cycle to a synchronous
// instruction memory while queue credit remains, buffers returned words in
// a 2-entry queue and hands them to decode over valid/ready. A redirect from
// execute flushes everything younger and restarts fetch at the target.
// Optional: define IFETCH_STALL_CNT_EN to add the stall_cnt output, a
// saturating count of cycles where decode was ready but nothing was valid.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef IFETCH_STALL_CNT_EN
    output logic [31:0]        stall_cnt,
`endif
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [5:0]         out_op,
    output logic [5:0]         out_funct
);

    logic [31:0]  fetch_pc;
    logic         inflight;
    logic [31:0]  inflight_pc;
    logic [1:0]   cnt;
    logic         pop;
    logic         push;
    logic         issue;
    logic [2:0]   occupancy;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid & out_ready;

    // Slots that will be occupied after this cycle if nothing new is issued:
    // queued words plus the word coming back, minus the one leaving.
    assign occupancy = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};

    // A read is only issued when its word is guaranteed a queue slot
    assign issue     = rst_n & ~redirect_valid & (occupancy < 3'd2);
    assign imem_en   = issue;
    assign imem_addr = fetch_pc[IMEM_AW+1:2];

    // The returning word is dropped on redirect; the queue is flushed anyway
    assign push       = inflight & ~redirect_valid;
    assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

    // Fetch PC and in-flight read tracking; redirect wins over issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= PC_RESET;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
        end
    end

    fetch_fifo2 #(
        .W(FETCH_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_entry),
        .cnt   (cnt)
    );

    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;
    assign out_op    = instr_op(head_entry.instr);
    assign out_funct = instr_funct(head_entry.instr);

`ifdef IFETCH_STALL_CNT_EN
    // Count decode-starved cycles, not the redirect cycle, saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_ready & ~out_valid & ~redirect_valid & (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
